// File: rtl/tick_gen.sv
// tick_gen: programmable tick generator with burst / continuous modes.
// A prescaler divides clk by (div_q + 1); each prescaler terminal count
// issues a one-cycle tick. A burst of burst_len ticks ends with a done
// pulse coincident with the last tick; burst_len == 0 runs until stop.
module tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       burst_len,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [3:0]       ticks_left
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_q, div_q_nxt;
    logic [DIV_W-1:0] pcnt, pcnt_nxt;
    logic             mode_q, mode_q_nxt;
    logic             tick_nxt, busy_nxt, done_nxt;
    logic [3:0]       ticks_left_nxt;

    logic accept;
    logic tick_due;
    logic last_tick;

    assign accept    = start && !stop;
    assign tick_due  = (pcnt == div_q);
    assign last_tick = !mode_q && (ticks_left == 4'd1);

    // State and all registered outputs/datapath, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_q      <= '0;
            pcnt       <= '0;
            mode_q     <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ticks_left <= '0;
        end else begin
            state      <= state_nxt;
            div_q      <= div_q_nxt;
            pcnt       <= pcnt_nxt;
            mode_q     <= mode_q_nxt;
            tick       <= tick_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ticks_left <= ticks_left_nxt;
        end
    end

    // Next-state: stop always wins; a burst ends on its final tick
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tick_due && last_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of outputs and datapath; tick/done are single-cycle pulses
    always_comb begin
        div_q_nxt      = div_q;
        pcnt_nxt       = pcnt;
        mode_q_nxt     = mode_q;
        tick_nxt       = 1'b0;
        done_nxt       = 1'b0;
        busy_nxt       = busy;
        ticks_left_nxt = ticks_left;
        case (state)
            IDLE: begin
                if (accept) begin
                    div_q_nxt      = div;
                    pcnt_nxt       = '0;
                    ticks_left_nxt = burst_len;
                    mode_q_nxt     = (burst_len == 4'd0);
                    busy_nxt       = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    busy_nxt       = 1'b0;
                    ticks_left_nxt = '0;
                    pcnt_nxt       = '0;
                end else if (!tick_due) begin
                    pcnt_nxt = pcnt + 1'b1;
                end else begin
                    tick_nxt = 1'b1;
                    pcnt_nxt = '0;
                    if (!mode_q) begin
                        ticks_left_nxt = ticks_left - 4'd1;
                    end
                    if (last_tick) begin
                        done_nxt = 1'b1;
                        busy_nxt = 1'b0;
                    end
                end
            end
            default: begin
                busy_nxt       = 1'b0;
                ticks_left_nxt = '0;
                pcnt_nxt       = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen. Expected tick events are
// derived arithmetically from each accepted transaction (tick k lands on
// cycle a + k*(div+1)) and queued; a negedge monitor pops and compares.
module tb_tick_gen;

    localparam int DIV_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [3:0]       burst_len;
    logic             tick;
    logic             busy;
    logic             done;
    logic [3:0]       ticks_left;

    tick_gen #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .div        (div),
        .burst_len  (burst_len),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .ticks_left (ticks_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: sample taken after posedge number cyc
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 4-bit counter enabled by tick
    logic [3:0] q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (tick) q <= q + 4'd1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        logic        done;
    } ev_t;
    ev_t sb[$];

    // Reference window of the current transaction
    int unsigned exp_a    = 0;
    int unsigned exp_end  = 0;
    int unsigned exp_n    = 0;
    int unsigned exp_p    = 1;
    bit          exp_cont = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_busy(input int unsigned c);
        return (c >= exp_a && c < exp_end) ? 1 : 0;
    endfunction

    function automatic int exp_tl(input int unsigned c);
        if (c >= exp_a && c < exp_end && !exp_cont)
            return int'(exp_n - (c - exp_a) / exp_p);
        return 0;
    endfunction

    // Monitor: per-cycle busy/ticks_left, tick events from scoreboard
    always @(negedge clk) begin
        chk("busy", int'(busy), exp_busy(cyc));
        chk("ticks_left", int'(ticks_left), exp_tl(cyc));
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_tick: expected tick at cycle %0d, still absent at cycle %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (tick) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("done_with_tick", int'(done), int'(sb[0].done));
                void'(sb.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL spurious_tick @cycle %0d: got tick=1, expected tick=0", cyc);
            end
        end else begin
            chk("done_without_tick", int'(done), 0);
        end
    end

    // Load the model for a start accepted at edge a
    task automatic model_start(input int unsigned a, input int unsigned d,
                               input int unsigned n, input int unsigned l);
        int unsigned p;
        int unsigned k;
        ev_t e;
        p = d + 1;
        exp_a    = a;
        exp_p    = p;
        exp_n    = n;
        exp_cont = (n == 0);
        exp_end  = (l != 0) ? a + l : a + n * p;
        k = 1;
        while ((exp_cont || k <= n) && (l == 0 || k * p < l)) begin
            e.cyc  = a + k * p;
            e.done = !exp_cont && (k == n);
            sb.push_back(e);
            k++;
        end
    endtask

    // Called at a negedge; returns at the negedge of the final cycle.
    // l != 0: stop is sampled at edge a+l. Inputs are scrambled while running.
    task automatic run(input int unsigned d, input int unsigned n, input int unsigned l);
        int unsigned a;
        start     = 1'b1;
        stop      = 1'b0;
        div       = DIV_W'(d);
        burst_len = 4'(n);
        a = cyc + 1;
        model_start(a, d, n, l);
        @(negedge clk);
        while (cyc < exp_end) begin
            start     = 1'($urandom);
            div       = DIV_W'($urandom);
            burst_len = 4'($urandom);
            stop      = (l != 0) && (cyc == a + l - 1);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Reset pulse placed between clock edges
    task automatic reset_between_edges();
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        exp_end = cyc;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc >= cyc) sb.delete(i);
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ticks_left", int'(ticks_left), 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int unsigned rd, rn, rl, gap;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        div       = '0;
        burst_len = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ticks_left", int'(ticks_left), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic burst: ticks after edges 3, 6, 9
        run(2, 3, 0);
        @(negedge clk);
        // Continuous, div 0, stop after 10 cycles
        run(0, 0, 10);
        @(negedge clk);
        // Stop exactly when a tick is due
        run(3, 2, 4);
        @(negedge clk);
        // start and stop together in IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        div   = 8'd1;
        burst_len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", int'(busy), 0);
        chk("start_stop_tick", int'(tick), 0);
        @(negedge clk);

        // Reset mid-run, then a single-tick burst
        start     = 1'b1;
        div       = 8'd1;
        burst_len = 4'd5;
        model_start(cyc + 1, 1, 5, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_between_edges();
        run(1, 1, 0);
        @(negedge clk);

        // Randomized transactions, including back-to-back bursts
        for (int t = 0; t < 30; t++) begin
            rd = $urandom_range(0, 4);
            rn = $urandom_range(0, 5);
            if (rn == 0) rl = $urandom_range(1, 20);
            else if ($urandom_range(0, 1) == 1) rl = $urandom_range(1, rn * (rd + 1));
            else rl = 0;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run(rd, rn, rl);
        end
        @(negedge clk);

        // Downstream counter: 15 ticks fill it, a second burst wraps to 14
        reset_between_edges();
        chk("counter_reset", int'(q), 0);
        run(1, 15, 0);
        @(negedge clk);
        chk("counter_first_burst", int'(q), 15);
        run(1, 15, 0);
        @(negedge clk);
        chk("counter_second_burst", int'(q), 14);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
